// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl
//   Scans a 4x4 keypad one column at a time, debounces whole-frame results and
//   queues one event per debounced key press in a small FIFO drained through a
//   valid/ack handshake.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   rows       : keypad rows, active-low, asynchronous to clk
//   cols       : column strobes, active-low one-hot
//   key_valid  : FIFO non-empty, key_code holds the head entry
//   key_code   : {release_flag, row[1:0], col[1:0]} at the FIFO head
//   key_ack    : pop request, only honoured while key_valid=1
//   overflow   : sticky, an event was dropped on a full FIFO
//   fifo_level : current FIFO occupancy
//
// Build option
//   KEY_RELEASE_EN : when defined, a debounced release of the reported key
//                    queues a release event (release_flag=1). When undefined,
//                    releases are silent and key_code[4] stays 0.

module key_scan_ctrl #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  rows,
    output logic [3:0]                  cols,
    output logic                        key_valid,
    output logic [4:0]                  key_code,
    input  logic                        key_ack,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DB_MAX   = 4'(DEBOUNCE_SCANS);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // Frame result kinds
    localparam logic [1:0] RES_NONE  = 2'd0;
    localparam logic [1:0] RES_KEY   = 2'd1;
    localparam logic [1:0] RES_MULTI = 2'd2;

    // ---------------- state ----------------
    logic [3:0]       rows_meta_q, rows_sync_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_q;
    logic [1:0]       acc_cnt_q;      // pressed bits so far this frame, 2 = two or more
    logic [3:0]       acc_code_q;
    logic [1:0]       cand_kind_q, cand_kind_d;
    logic [3:0]       cand_code_q, cand_code_d;
    logic [3:0]       stable_q, stable_d;
    logic             rep_key_q, rep_key_d;
    logic [3:0]       rep_code_q, rep_code_d;

    logic [4:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [4:0]       code_q, code_d;
    logic             ovf_q, ovf_d;

    // ---------------- scan / frame tally ----------------
    logic       col_end, frame_end;
    logic [2:0] hits;
    logic [1:0] hit_row;
    logic [1:0] tot_cnt;
    logic [3:0] tot_code;
    logic [1:0] res_kind;

    always_comb begin
        col_end   = (div_q == DIV_LAST);
        frame_end = col_end && (col_q == 2'd3);

        hits    = '0;
        hit_row = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!rows_sync_q[r]) begin
                hits    = hits + 3'd1;
                hit_row = 2'(r);
            end
        end

        // Merge this column's sample into the running frame tally.
        if (hits >= 3'd2 || acc_cnt_q == 2'd2 || (hits == 3'd1 && acc_cnt_q == 2'd1))
            tot_cnt = 2'd2;
        else if (hits == 3'd1 || acc_cnt_q == 2'd1)
            tot_cnt = 2'd1;
        else
            tot_cnt = 2'd0;

        tot_code = (hits == 3'd1 && acc_cnt_q == 2'd0) ? {hit_row, col_q} : acc_code_q;

        case (tot_cnt)
            2'd0:    res_kind = RES_NONE;
            2'd1:    res_kind = RES_KEY;
            default: res_kind = RES_MULTI;
        endcase
    end

    // ---------------- debounce / event generation ----------------
    logic       same, accept;
    logic       push_req;
    logic [4:0] push_data;

    always_comb begin
        cand_kind_d = cand_kind_q;
        cand_code_d = cand_code_q;
        stable_d    = stable_q;
        rep_key_d   = rep_key_q;
        rep_code_d  = rep_code_q;
        accept      = 1'b0;
        push_req    = 1'b0;
        push_data   = '0;
        same        = (res_kind == cand_kind_q) &&
                      (res_kind != RES_KEY || tot_code == cand_code_q);

        if (frame_end) begin
            if (same) begin
                if (stable_q != DB_MAX)
                    stable_d = stable_q + 4'd1;
                // Accept only on the frame the count reaches the threshold.
                accept = (stable_q == DB_MAX - 4'd1);
            end else begin
                cand_kind_d = res_kind;
                cand_code_d = tot_code;
                stable_d    = 4'd1;
                accept      = (DB_MAX == 4'd1);
            end

            if (res_kind == RES_MULTI) begin
                stable_d = '0;
                accept   = 1'b0;
            end

            if (accept) begin
                if (res_kind == RES_KEY) begin
                    if (!rep_key_q || rep_code_q != tot_code) begin
                        push_req  = 1'b1;
                        push_data = {1'b0, tot_code};
                    end
                    rep_key_d  = 1'b1;
                    rep_code_d = tot_code;
                end else begin
`ifdef KEY_RELEASE_EN
                    if (rep_key_q) begin
                        push_req  = 1'b1;
                        push_data = {1'b1, rep_code_q};
                    end
`endif
                    rep_key_d = 1'b0;
                end
            end
        end
    end

    // ---------------- event FIFO ----------------
    logic pop, full, push_ok, empty_after_pop;

    always_comb begin
        pop             = (level_q != '0) && key_ack;
        full            = (level_q == LVL_FULL);
        push_ok         = push_req && (!full || pop);
        ovf_d           = ovf_q | (push_req && full && !pop);
        empty_after_pop = (level_q == LVL_W'(1)) && pop || (level_q == '0);

        wptr_d  = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop     ? rptr_q + PTR_W'(1) : rptr_q;
        level_d = level_q;
        if (push_ok && !pop)
            level_d = level_q + LVL_W'(1);
        else if (!push_ok && pop)
            level_d = level_q - LVL_W'(1);

        // Registered head: a push into an (effectively) empty FIFO is the new
        // head directly; otherwise the already-stored entry at the new read
        // pointer. Hold the last code while empty.
        code_d = code_q;
        if (push_ok && empty_after_pop)
            code_d = push_data;
        else if (level_d != '0)
            code_d = mem_q[rptr_d];
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rows_meta_q <= '1;
            rows_sync_q <= '1;
            div_q       <= '0;
            col_q       <= '0;
            acc_cnt_q   <= '0;
            acc_code_q  <= '0;
            cand_kind_q <= RES_NONE;
            cand_code_q <= '0;
            stable_q    <= '0;
            rep_key_q   <= 1'b0;
            rep_code_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            code_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            rows_meta_q <= rows;
            rows_sync_q <= rows_meta_q;
            if (col_end) begin
                div_q      <= '0;
                col_q      <= col_q + 2'd1;
                acc_cnt_q  <= frame_end ? 2'd0 : tot_cnt;
                acc_code_q <= frame_end ? 4'd0 : tot_code;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
            cand_kind_q <= cand_kind_d;
            cand_code_q <= cand_code_d;
            stable_q    <= stable_d;
            rep_key_q   <= rep_key_d;
            rep_code_q  <= rep_code_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            code_q      <= code_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by level_q alone.
    always_ff @(posedge clk) begin
        if (push_ok && !rst)
            mem_q[wptr_q] <= push_data;
    end

    assign cols       = ~(4'b0001 << col_q);
    assign key_valid  = (level_q != '0);
    assign key_code   = code_q;
    assign overflow   = ovf_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Testbench for key_scan_ctrl with SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=2.
// A keypad model turns a 16-bit pressed-key matrix into row levels from the
// live column strobes. A frame-level reference model predicts every output.

module tb_key_scan_ctrl;

    localparam int unsigned SD    = 4;
    localparam int unsigned DB    = 2;
    localparam int unsigned DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_valid;
    logic [4:0] key_code;
    logic       key_ack = 1'b0;
    logic       overflow;
    logic [1:0] fifo_level;

    logic [15:0] mat = '0;   // bit r*4+c set = key (row r, col c) held down

    int checks   = 0;
    int failures = 0;

    key_scan_ctrl #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_SCANS(DB),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rows      (rows),
        .cols      (cols),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ack   (key_ack),
        .overflow  (overflow),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Row r is pulled low when a held key in that row sits on the driven column.
    always_comb begin
        for (int r = 0; r < 4; r++)
            rows[r] = ~|(mat[r*4 +: 4] & ~cols);
    end

    // ---------------- reference model ----------------
    int          cyc  = 0;
    bit          live = 0;
    int          cand_kind, cand_code, stable, rep_key, rep_code;
    logic [4:0]  q[$];
    logic [4:0]  exp_code;
    bit          exp_ovf;
    int          m_n, m_kind, m_code;
    bit          m_reach, m_pop, m_push;
    logic [4:0]  m_pd;

    always @(posedge clk) begin
        if (rst) begin
            cyc = 0; live = 1;
            cand_kind = 0; cand_code = 0; stable = 0;
            rep_key = 0; rep_code = 0;
            q.delete(); exp_code = '0; exp_ovf = 0;
        end else begin
            m_pop  = (q.size() > 0) && key_ack;
            m_push = 0;
            m_pd   = '0;
            if (cyc % 16 == 15) begin
                m_n    = $countones(mat);
                m_code = 0;
                for (int i = 0; i < 16; i++) if (mat[i]) m_code = i;
                m_kind = (m_n == 0) ? 0 : (m_n == 1) ? 1 : 2;
                if (m_kind == cand_kind && (m_kind != 1 || m_code == cand_code)) begin
                    m_reach = (stable == DB - 1);
                    if (stable < DB) stable++;
                end else begin
                    cand_kind = m_kind; cand_code = m_code; stable = 1;
                    m_reach = (DB == 1);
                end
                if (m_kind == 2) begin stable = 0; m_reach = 0; end
                if (m_reach) begin
                    if (m_kind == 1) begin
                        if (!rep_key || rep_code != m_code) begin
                            m_push = 1; m_pd = {1'b0, 4'(m_code)};
                        end
                        rep_key = 1; rep_code = m_code;
                    end else begin
`ifdef KEY_RELEASE_EN
                        if (rep_key) begin m_push = 1; m_pd = {1'b1, 4'(rep_code)}; end
`endif
                        rep_key = 0;
                    end
                end
            end
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                if (q.size() == DEPTH) exp_ovf = 1;
                else q.push_back(m_pd);
            end
            if (q.size() > 0) exp_code = q[0];
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Continuous compare against the model, away from the active edge.
    logic [3:0] exp_cols;
    initial forever begin
        @(negedge clk);
        if (live) begin
            exp_cols = 4'b1111;
            exp_cols[(cyc / SD) % 4] = 1'b0;
            chk("model_cols",  cols, exp_cols);
            chk("model_valid", key_valid, (q.size() > 0));
            chk("model_level", fifo_level, q.size());
            chk("model_code",  key_code, exp_code);
            chk("model_ovf",   overflow, exp_ovf);
        end
    end

    // Advance to the negedge inside cycle n (bounded).
    task automatic wait_until(input int n);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc != n && guard < 2000);
        if (cyc != n) begin
            checks++; failures++;
            $display("FAIL wait_until: got cycle %0d expected %0d", cyc, n);
        end
    endtask

`ifdef KEY_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    int r_pick, b0, b1;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Reset state and column rotation
        chk("rst_cols", cols, 4'b1110);
        chk("rst_valid", key_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_code", key_code, 0);
        chk("rst_ovf", overflow, 0);
        wait_until(4);  chk("cols_c1", cols, 4'b1101);
        wait_until(8);  chk("cols_c2", cols, 4'b1011);
        wait_until(12); chk("cols_c3", cols, 4'b0111);
        wait_until(16); chk("cols_wrap", cols, 4'b1110); chk("idle_valid", key_valid, 0);

        // Held key row2/col1 for frames 2..4
        wait_until(32); mat = 16'h0001 << 9;
        wait_until(63); chk("hold_valid_before", key_valid, 0);
        wait_until(64); chk("hold_valid_after", key_valid, 1);
        chk("hold_code", key_code, 5'b0_10_01);
        chk("hold_level", fifo_level, 1);

        // Bouncing row0/col0, then stable
        wait_until(80); mat = 16'h0001; chk("hold_single_event", fifo_level, 1);
        wait_until(81); key_ack = 1'b1;
        wait_until(82); key_ack = 1'b0;
        chk("ack_valid", key_valid, 0); chk("ack_code_hold", key_code, 5'b0_10_01);
        wait_until(96);  mat = '0;
        wait_until(112); mat = 16'h0001;
        wait_until(128); mat = '0;
        wait_until(144); mat = 16'h0001;
        wait_until(175); chk("bounce_no_early", fifo_level, 0);
        // MULTI: rows 1 and 3 in col 2
        wait_until(176); mat = (16'h0001 << 6) | (16'h0001 << 14);
        chk("bounce_valid", key_valid, 1); chk("bounce_code", key_code, 5'b0_00_00);
        wait_until(177); key_ack = 1'b1;
        wait_until(178); key_ack = 1'b0; chk("bounce_drained", fifo_level, 0);

        // Overflow with no acks
        wait_until(240); chk("multi_level", fifo_level, 0); chk("multi_ovf", overflow, 0);
        mat = 16'h0001 << 5;
        wait_until(272); mat = 16'h0001 << 12; chk("ovf_l1", fifo_level, 1); chk("ovf_c1", key_code, 5'b0_01_01);
        wait_until(304); mat = 16'h0001 << 3;  chk("ovf_l2", fifo_level, 2);
        wait_until(336); mat = 16'h0001 << 10;
        chk("ovf_full", fifo_level, 2); chk("ovf_flag", overflow, 1); chk("ovf_head", key_code, 5'b0_01_01);
        wait_until(367); key_ack = 1'b1;
        wait_until(368); key_ack = 1'b0; mat = 16'h0001 << 15;
        chk("pushpop_level", fifo_level, 2); chk("pushpop_head", key_code, 5'b0_11_00);
        wait_until(369); key_ack = 1'b1;
        wait_until(370); chk("drain_head", key_code, 5'b0_10_10); chk("drain_level", fifo_level, 1);
        wait_until(371); key_ack = 1'b0; chk("drain_empty", key_valid, 0); chk("drain_hold", key_code, 5'b0_10_10);

        // Press / release row3/col3
        wait_until(400); mat = '0; chk("rel_press", key_code, 5'b0_11_11); chk("rel_l1", fifo_level, 1);
        wait_until(432); chk("rel_level", fifo_level, REL ? 2 : 1); key_ack = 1'b1;
        wait_until(433); key_ack = 1'b0;
        chk("rel_code", key_code, REL ? 5'b1_11_11 : 5'b0_11_11);
        chk("rel_level2", fifo_level, REL ? 1 : 0);

        // Reset mid-frame
        wait_until(440); rst = 1'b1;
        wait_until(0);   rst = 1'b0;
        chk("midrst_cols", cols, 4'b1110); chk("midrst_valid", key_valid, 0);
        chk("midrst_ovf", overflow, 0);    chk("midrst_level", fifo_level, 0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = 1'b0;
            if (cyc % 16 == 0) begin
                r_pick = $urandom_range(0, 99);
                if (r_pick < 50) begin
                    // keep the current matrix
                end else if (r_pick < 65) begin
                    mat = '0;
                end else if (r_pick < 90) begin
                    mat = 16'h0001 << $urandom_range(0, 15);
                end else begin
                    b0 = $urandom_range(0, 15);
                    b1 = (b0 + $urandom_range(1, 15)) % 16;
                    mat = (16'h0001 << b0) | (16'h0001 << b1);
                end
            end
            key_ack = ($urandom_range(0, 3) == 0);
            if (cyc % 16 == 7 && $urandom_range(0, 59) == 0) rst = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
